mux_nx1_scan: RTL and testbench

Registered N-channel, BITS-wide multiplexer. It is the successor to the 2-input combinational mux used in the PlaySeq datapath.
- Manual mode: the channel is chosen by SEL.
- Scan mode: the block steps through channels automatically, one every SCAN_PERIOD clocks. This drives LED/display round-robin and sequence playback.
- OUT is registered, with a load enable, an invalid-select flag and a wrap pulse.

---
 rtl/mux_nx1_scan.sv | 166 ++++++++++++++++
 tb/tb_mux_nx1_scan.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_nx1_scan                                                             |
// | Registered N-channel mux with manual select or automatic round-robin     |
// | scan. Scan mode is built only when MUX_SCAN_EN is defined.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_nx1_scan #(
    parameter int BITS        = 4,
    parameter int CHANNELS    = 4,
    parameter int SEL_BITS    = 2,
    parameter int SCAN_PERIOD = 50
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CHANNELS*BITS-1:0] D,
    input  logic [SEL_BITS-1:0]      SEL,
    input  logic                     MODE,
    input  logic                     ENABLE,
    output logic [BITS-1:0]          OUT,
    output logic [SEL_BITS-1:0]      CUR_SEL,
    output logic                     SEL_ERR,
    output logic                     WRAP
);

    localparam logic [SEL_BITS:0] c_channels = (SEL_BITS+1)'(CHANNELS);

    // Index decode never reaches past the last channel, so no X escapes.
    function automatic logic [BITS-1:0] pick(input logic [SEL_BITS-1:0] idx);
        logic [BITS-1:0] v;
        v = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_BITS'(k)) begin
                v = D[k*BITS +: BITS];
            end
        end
        return v;
    endfunction

    logic                w_sel_ok;
    logic [BITS-1:0]     w_man_out;
    logic [BITS-1:0]     r_out;
    logic [SEL_BITS-1:0] r_cur_sel;
    logic                r_sel_err;
    logic [BITS-1:0]     w_out_nxt;
    logic [SEL_BITS-1:0] w_cur_nxt;
    logic                w_err_nxt;

    assign w_sel_ok  = ({1'b0, SEL} < c_channels);
    assign w_man_out = w_sel_ok ? pick(SEL) : '1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out     <= '0;
            r_cur_sel <= '0;
            r_sel_err <= 1'b0;
        end else begin
            r_out     <= w_out_nxt;
            r_cur_sel <= w_cur_nxt;
            r_sel_err <= w_err_nxt;
        end
    end

    assign OUT     = r_out;
    assign CUR_SEL = r_cur_sel;
    assign SEL_ERR = r_sel_err;

`ifdef MUX_SCAN_EN
    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    localparam int                  c_cnt_w    = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(SCAN_PERIOD - 1);
    localparam logic [SEL_BITS-1:0] c_last_ch  = SEL_BITS'(CHANNELS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [SEL_BITS-1:0] r_ptr;
    logic [SEL_BITS-1:0] w_ptr_nxt;
    logic [SEL_BITS-1:0] w_ld_ptr;
    logic                r_wrap;
    logic                w_wrap_nxt;

    assign w_ld_ptr = w_sel_ok ? SEL : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_MANUAL;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // State follows MODE even while disabled; everything else needs ENABLE.
    always_comb begin
        w_state_nxt = MODE ? ST_SCAN : ST_MANUAL;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_wrap_nxt  = 1'b0;
        w_out_nxt   = r_out;
        w_cur_nxt   = r_cur_sel;
        w_err_nxt   = r_sel_err;
        if (ENABLE) begin
            if (!MODE) begin
                w_out_nxt = w_man_out;
                w_cur_nxt = SEL;
                w_err_nxt = !w_sel_ok;
                w_cnt_nxt = '0;
            end else if (r_state == ST_MANUAL) begin
                w_ptr_nxt = w_ld_ptr;
                w_cnt_nxt = '0;
                w_out_nxt = pick(w_ld_ptr);
                w_cur_nxt = w_ld_ptr;
                w_err_nxt = 1'b0;
            end else begin
                w_out_nxt = pick(r_ptr);
                w_cur_nxt = r_ptr;
                w_err_nxt = 1'b0;
                if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_ptr == c_last_ch) begin
                        w_ptr_nxt  = '0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end
    end

    assign WRAP = r_wrap;
`else
    localparam int c_unused_period = SCAN_PERIOD;
    logic          w_unused_mode;

    assign w_unused_mode = MODE;

    always_comb begin
        w_out_nxt = r_out;
        w_cur_nxt = r_cur_sel;
        w_err_nxt = r_sel_err;
        if (ENABLE) begin
            w_out_nxt = w_man_out;
            w_cur_nxt = SEL;
            w_err_nxt = !w_sel_ok;
        end
    end

    assign WRAP = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_nx1_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mux_nx1_scan                                                          |
// | Directed-vector bench for mux_nx1_scan (3 channels, 4 bits, period 2).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mux_nx1_scan;

    localparam int BITS        = 4;
    localparam int CHANNELS    = 3;
    localparam int SEL_BITS    = 2;
    localparam int SCAN_PERIOD = 2;
    localparam logic [11:0] c_d_def = {4'hC, 4'h5, 4'hA};

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] D;
    logic [1:0]  SEL;
    logic        MODE;
    logic        ENABLE;
    logic [3:0]  OUT;
    logic [1:0]  CUR_SEL;
    logic        SEL_ERR;
    logic        WRAP;
    logic [7:0]  obs;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign obs = {OUT, CUR_SEL, SEL_ERR, WRAP};

    mux_nx1_scan #(
        .BITS        (BITS),
        .CHANNELS    (CHANNELS),
        .SEL_BITS    (SEL_BITS),
        .SCAN_PERIOD (SCAN_PERIOD)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .D       (D),
        .SEL     (SEL),
        .MODE    (MODE),
        .ENABLE  (ENABLE),
        .OUT     (OUT),
        .CUR_SEL (CUR_SEL),
        .SEL_ERR (SEL_ERR),
        .WRAP    (WRAP)
    );

    function automatic logic [7:0] ex(input logic [3:0] o, input logic [1:0] c,
                                      input logic e, input logic w);
        return {o, c, e, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; MODE = 1'b1; ENABLE = 1'b1; SEL = 2'd1; D = c_d_def;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (obs !== 8'h00) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h want %h", i, obs, 8'h00);
            end
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (obs !== ex(4'h5, 2'd1, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obs, ex(4'h5, 2'd1, 1'b0, 1'b0));
        end
    endtask

    task automatic test_manual();
        logic [7:0] want [4];
        want[0] = ex(4'hA, 2'd0, 1'b0, 1'b0);
        want[1] = ex(4'h5, 2'd1, 1'b0, 1'b0);
        want[2] = ex(4'hC, 2'd2, 1'b0, 1'b0);
        want[3] = ex(4'hF, 2'd3, 1'b1, 1'b0);
        MODE = 1'b0; ENABLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            SEL = 2'(i);
            tick();
            n_vec++;
            if (obs !== want[i]) begin
                n_err++;
                $display("FAIL manual[sel=%0d]: got %h want %h", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic       en   [9];
        logic [1:0] sel  [9];
        logic [7:0] want [9];
        en[0] = 1'b1; sel[0] = 2'd1; want[0] = ex(4'h5, 2'd1, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++) begin
            en[i] = 1'b0; sel[i] = 2'd2; want[i] = ex(4'h5, 2'd1, 1'b0, 1'b0);
        end
        en[6] = 1'b1; sel[6] = 2'd2; want[6] = ex(4'hC, 2'd2, 1'b0, 1'b0);
        en[7] = 1'b1; sel[7] = 2'd3; want[7] = ex(4'hF, 2'd3, 1'b1, 1'b0);
        en[8] = 1'b0; sel[8] = 2'd0; want[8] = ex(4'hF, 2'd3, 1'b1, 1'b0);
        MODE = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ENABLE = en[i]; SEL = sel[i];
            tick();
            n_vec++;
            if (obs !== want[i]) begin
                n_err++;
                $display("FAIL hold[%0d]: got %h want %h", i, obs, want[i]);
            end
        end
        ENABLE = 1'b1;
    endtask

`ifdef MUX_SCAN_EN
    task automatic test_scan();
        logic       en   [12];
        logic [7:0] want [12];
        for (int i = 0; i < 12; i++) en[i] = 1'b1;
        en[5] = 1'b0; en[6] = 1'b0;
        want[0]  = ex(4'h5, 2'd1, 1'b0, 1'b0);
        want[1]  = ex(4'h5, 2'd1, 1'b0, 1'b0);
        want[2]  = ex(4'h5, 2'd1, 1'b0, 1'b0);
        want[3]  = ex(4'hC, 2'd2, 1'b0, 1'b0);
        want[4]  = ex(4'hC, 2'd2, 1'b0, 1'b1);
        want[5]  = ex(4'hC, 2'd2, 1'b0, 1'b0);
        want[6]  = ex(4'hC, 2'd2, 1'b0, 1'b0);
        want[7]  = ex(4'hA, 2'd0, 1'b0, 1'b0);
        want[8]  = ex(4'hA, 2'd0, 1'b0, 1'b0);
        want[9]  = ex(4'h5, 2'd1, 1'b0, 1'b0);
        want[10] = ex(4'h5, 2'd1, 1'b0, 1'b0);
        want[11] = ex(4'hC, 2'd2, 1'b0, 1'b0);
        SEL = 2'd1; MODE = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ENABLE = en[i];
            tick();
            n_vec++;
            if (obs !== want[i]) begin
                n_err++;
                $display("FAIL scan[%0d]: got %h want %h", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_scan_oob_load();
        logic [7:0] want [4];
        want[0] = ex(4'hA, 2'd0, 1'b0, 1'b0);
        want[1] = ex(4'hA, 2'd0, 1'b0, 1'b0);
        want[2] = ex(4'hA, 2'd0, 1'b0, 1'b0);
        want[3] = ex(4'h5, 2'd1, 1'b0, 1'b0);
        D = c_d_def; SEL = 2'd3; MODE = 1'b1; ENABLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (obs !== want[i]) begin
                n_err++;
                $display("FAIL scan_oob[%0d]: got %h want %h", i, obs, want[i]);
            end
        end
    endtask
`else
    task automatic test_no_scan();
        MODE = 1'b1; SEL = 2'd2; ENABLE = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if (obs !== ex(4'hC, 2'd2, 1'b0, 1'b0)) begin
                n_err++;
                $display("FAIL no_scan[%0d]: got %h want %h", i, obs, ex(4'hC, 2'd2, 1'b0, 1'b0));
            end
        end
        SEL = 2'd3;
        tick();
        n_vec++;
        if (obs !== ex(4'hF, 2'd3, 1'b1, 1'b0)) begin
            n_err++;
            $display("FAIL no_scan_oob: got %h want %h", obs, ex(4'hF, 2'd3, 1'b1, 1'b0));
        end
    endtask
`endif

    // Leaving scan on the clock that would have wrapped must give manual data, no pulse.
    task automatic test_mode_switch();
        MODE = 1'b0; SEL = 2'd0; ENABLE = 1'b1;
        tick();
        n_vec++;
        if (obs !== ex(4'hA, 2'd0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL mode_drop: got %h want %h", obs, ex(4'hA, 2'd0, 1'b0, 1'b0));
        end
        D[3:0] = 4'h3;
        tick();
        n_vec++;
        if (obs !== ex(4'h3, 2'd0, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL live_data: got %h want %h", obs, ex(4'h3, 2'd0, 1'b0, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_enable_hold();
`ifdef MUX_SCAN_EN
        test_scan();
        test_mode_switch();
        test_scan_oob_load();
`else
        test_no_scan();
        test_mode_switch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
